// File: rtl/matrix_uart_host.sv
// matrix_uart_host
// Host-side initiator for the UART matrix-multiply link. Sends a job frame
// (size byte N, then A and B row-major, N*N bytes each) one byte at a time
// through a UART transmitter. It then collects 2*N*N result bytes, high byte
// first, and rebuilds the 16-bit row-major result matrix for local readback.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, size              launch a job of N = size (pulse)
//   mat_wr_*                 operand load port (ignored while busy)
//   res_rd_addr/res_rd_data  result readback, 1-cycle registered latency
//   tx_byte, tx_start, tx_busy   byte transmitter handshake
//   rx_byte, rx_done         byte receiver (rising edge of rx_done = new byte)
//   busy, done, err, err_code    job status (err_code: 1 bad size, 2 rx timeout)
module matrix_uart_host #(
    parameter int MAX_SIZE   = 10,
    parameter int TX_GAP     = 12500,
    parameter int RX_TIMEOUT = 2000000,
    parameter int AW         = $clog2(MAX_SIZE * MAX_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    size,
    input  logic          mat_wr_en,
    input  logic          mat_wr_sel,
    input  logic [AW-1:0] mat_wr_addr,
    input  logic [7:0]    mat_wr_data,
    input  logic [AW-1:0] res_rd_addr,
    output logic [15:0]   res_rd_data,
    output logic [7:0]    tx_byte,
    output logic          tx_start,
    input  logic          tx_busy,
    input  logic [7:0]    rx_byte,
    input  logic          rx_done,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);
    localparam int DEPTH = MAX_SIZE * MAX_SIZE;
    localparam int CW    = AW + 1;
    localparam int GW    = $clog2(TX_GAP + 1);
    localparam int TW    = $clog2(RX_TIMEOUT + 1);
    localparam logic [7:0] MAX_N = 8'(MAX_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_TX_REQ, S_TX_WAIT, S_TX_GAP, S_RECV_HI, S_RECV_LO
    } state_t;

    state_t         state_r, state_s;
    logic [7:0]     mem_a [DEPTH];
    logic [7:0]     mem_b [DEPTH];
    logic [15:0]    res_mem [DEPTH];
    logic [7:0]     nn_r, nn_s;
    logic [CW-1:0]  byte_cnt_r, byte_cnt_s, word_idx_r, word_idx_s, nxt_idx_s;
    logic [GW-1:0]  gap_cnt_r, gap_cnt_s;
    logic [TW-1:0]  tmo_cnt_r, tmo_cnt_s;
    logic [7:0]     hi_r, hi_s, tx_byte_s, nxt_data_s;
    logic           tx_start_s, busy_s, done_s, err_s, res_we_s;
    logic [1:0]     err_code_s;
    logic           busy_meta_r, busy_sync_r, rx_done_q_r, rx_edge_s;
    logic           last_byte_s, last_word_s, tmo_hit_s;

    // tx_busy comes from the slow UART domain: two-flop synchroniser; rx_done edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_meta_r <= 1'b0;
            busy_sync_r <= 1'b0;
            rx_done_q_r <= 1'b0;
        end else begin
            busy_meta_r <= tx_busy;
            busy_sync_r <= busy_meta_r;
            rx_done_q_r <= rx_done;
        end
    end

    assign rx_edge_s   = rx_done & ~rx_done_q_r;
    assign last_byte_s = (byte_cnt_r == CW'({nn_r, 1'b0}));
    assign last_word_s = (word_idx_r == (CW'(nn_r) - CW'(1)));
    assign tmo_hit_s   = (tmo_cnt_r == TW'(RX_TIMEOUT - 1));

    // Frame byte that follows byte_cnt_r: index 0 is the size byte, 1..NN is A, then B
    always_comb begin
        nxt_idx_s = byte_cnt_r + CW'(1);
        if (nxt_idx_s <= CW'(nn_r)) begin
            nxt_data_s = mem_a[AW'(nxt_idx_s - CW'(1))];
        end else begin
            nxt_data_s = mem_b[AW'(nxt_idx_s - CW'(1) - CW'(nn_r))];
        end
    end

    // Next-state and next-output logic of the job sequencer
    always_comb begin
        state_s    = state_r;
        nn_s       = nn_r;
        byte_cnt_s = byte_cnt_r;
        word_idx_s = word_idx_r;
        gap_cnt_s  = gap_cnt_r;
        tmo_cnt_s  = tmo_cnt_r;
        hi_s       = hi_r;
        tx_byte_s  = tx_byte;
        tx_start_s = tx_start;
        busy_s     = busy;
        done_s     = 1'b0;
        err_s      = err;
        err_code_s = err_code;
        res_we_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if ((size < 8'd2) || (size > MAX_N)) begin
                        err_s      = 1'b1;
                        err_code_s = 2'd1;
                    end else begin
                        nn_s       = 8'(size * size);
                        byte_cnt_s = {CW{1'b0}};
                        word_idx_s = {CW{1'b0}};
                        tx_byte_s  = size;
                        tx_start_s = 1'b1;
                        busy_s     = 1'b1;
                        err_s      = 1'b0;
                        err_code_s = 2'd0;
                        state_s    = S_TX_REQ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TX_REQ: begin
                // keep requesting until the transmitter has taken the byte
                if (busy_sync_r) begin
                    tx_start_s = 1'b0;
                    state_s    = S_TX_WAIT;
                end else begin
                    tx_start_s = 1'b1;
                end
            end
            S_TX_WAIT: begin
                if (!busy_sync_r) begin
                    gap_cnt_s = {GW{1'b0}};
                    state_s   = S_TX_GAP;
                end else begin
                    state_s = S_TX_WAIT;
                end
            end
            S_TX_GAP: begin
                if (gap_cnt_r == GW'(TX_GAP - 1)) begin
                    if (last_byte_s) begin
                        tmo_cnt_s = {TW{1'b0}};
                        state_s   = S_RECV_HI;
                    end else begin
                        byte_cnt_s = nxt_idx_s;
                        tx_byte_s  = nxt_data_s;
                        tx_start_s = 1'b1;
                        state_s    = S_TX_REQ;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            S_RECV_HI, S_RECV_LO: begin
                if (rx_edge_s) begin
                    tmo_cnt_s = {TW{1'b0}};
                    if (state_r == S_RECV_HI) begin
                        hi_s    = rx_byte;
                        state_s = S_RECV_LO;
                    end else begin
                        res_we_s   = 1'b1;
                        word_idx_s = word_idx_r + CW'(1);
                        if (last_word_s) begin
                            done_s  = 1'b1;
                            busy_s  = 1'b0;
                            state_s = S_IDLE;
                        end else begin
                            state_s = S_RECV_HI;
                        end
                    end
                end else if (tmo_hit_s) begin
                    // abort passes through the error condition straight back to idle
                    err_s      = 1'b1;
                    err_code_s = 2'd2;
                    busy_s     = 1'b0;
                    state_s    = S_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            nn_r       <= 8'd0;
            byte_cnt_r <= {CW{1'b0}};
            word_idx_r <= {CW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            tmo_cnt_r  <= {TW{1'b0}};
            hi_r       <= 8'd0;
            tx_byte    <= 8'd0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state_r    <= state_s;
            nn_r       <= nn_s;
            byte_cnt_r <= byte_cnt_s;
            word_idx_r <= word_idx_s;
            gap_cnt_r  <= gap_cnt_s;
            tmo_cnt_r  <= tmo_cnt_s;
            hi_r       <= hi_s;
            tx_byte    <= tx_byte_s;
            tx_start   <= tx_start_s;
            busy       <= busy_s;
            done       <= done_s;
            err        <= err_s;
            err_code   <= err_code_s;
        end
    end

    // Operand and result storage (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (mat_wr_en && !busy && (int'(mat_wr_addr) < DEPTH)) begin
            if (mat_wr_sel) begin
                mem_b[mat_wr_addr] <= mat_wr_data;
            end else begin
                mem_a[mat_wr_addr] <= mat_wr_data;
            end
        end
        if (res_we_s && !rst) begin
            res_mem[word_idx_r[AW-1:0]] <= {hi_r, rx_byte};
        end
    end

    // Registered result readback; out-of-range addresses read as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            res_rd_data <= 16'd0;
        end else if (int'(res_rd_addr) < DEPTH) begin
            res_rd_data <= res_mem[res_rd_addr];
        end else begin
            res_rd_data <= 16'd0;
        end
    end
endmodule

// File: tb/tb_matrix_uart_host.sv
// tb_matrix_uart_host
// Self-checking bench for matrix_uart_host. A far-end UART model accepts the
// transmitted frame and checks it against a queue of expected bytes; result
// words come from a plain matrix-multiply reference model.
module tb_matrix_uart_host;
    localparam int MAX_SIZE   = 10;
    localparam int TX_GAP     = 8;
    localparam int RX_TIMEOUT = 200;
    localparam int AW         = 7;

    logic          clk = 1'b0;
    logic          rst, start, mat_wr_en, mat_wr_sel, tx_start, tx_busy, rx_done;
    logic          busy, done, err;
    logic [7:0]    size, mat_wr_data, tx_byte, rx_byte;
    logic [AW-1:0] mat_wr_addr, res_rd_addr;
    logic [15:0]   res_rd_data;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    matrix_uart_host #(.MAX_SIZE(MAX_SIZE), .TX_GAP(TX_GAP), .RX_TIMEOUT(RX_TIMEOUT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size),
        .mat_wr_en(mat_wr_en), .mat_wr_sel(mat_wr_sel), .mat_wr_addr(mat_wr_addr),
        .mat_wr_data(mat_wr_data), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_byte(rx_byte), .rx_done(rx_done),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tx_count = 0;
    int          tx_seen = 0;
    int          done_cnt = 0;
    int          busy_delay = 0;
    int          fall_cyc = -1;
    logic [7:0]  ma [100];
    logic [7:0]  mb [100];
    logic [7:0]  exp_tx [$];
    logic [15:0] words [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
        end
    endtask

    // Far-end transmitter: handshake, hold/stability/gap checks, frame scoreboard
    initial begin : tx_far_end
        logic [7:0] b;
        logic       held_ok, stable_ok;
        int         d, w;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                tx_seen++;
                if (fall_cyc >= 0) chk_ge("tx_gap", cyc - fall_cyc, TX_GAP);
                b = tx_byte;
                held_ok = 1'b1;
                stable_ok = 1'b1;
                d = (busy_delay > 0) ? busy_delay : int'($urandom_range(1, 4));
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (tx_start !== 1'b1) held_ok = 1'b0;
                    if (tx_byte !== b) stable_ok = 1'b0;
                end
                tx_busy = 1'b1;
                w = 0;
                while (tx_start === 1'b1 && w < 20) begin
                    @(negedge clk);
                    w++;
                    if (tx_byte !== b) stable_ok = 1'b0;
                end
                chk("tx_start_drop", {31'd0, tx_start}, 32'd0);
                repeat ($urandom_range(1, 5)) begin
                    @(negedge clk);
                    if (tx_byte !== b) stable_ok = 1'b0;
                end
                tx_busy = 1'b0;
                fall_cyc = cyc;
                chk("tx_start_held", {31'd0, held_ok}, 32'd1);
                chk("tx_byte_stable", {31'd0, stable_ok}, 32'd1);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no byte", b);
                end else begin
                    chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
                end
                tx_count++;
            end
        end
    end

    // Done monitor: count pulses, busy must already be low in the done cycle
    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic wr(input logic sel, input int addr, input logic [7:0] data);
        @(negedge clk);
        mat_wr_en = 1'b1; mat_wr_sel = sel; mat_wr_addr = AW'(addr); mat_wr_data = data;
        @(negedge clk);
        mat_wr_en = 1'b0;
    endtask

    task automatic load_dut(input int n);
        for (int i = 0; i < n * n; i++) begin
            wr(1'b0, i, ma[i]);
            wr(1'b1, i, mb[i]);
        end
    endtask

    task automatic rand_mats(input int n);
        for (int i = 0; i < n * n; i++) begin
            ma[i] = 8'($urandom_range(0, 255));
            mb[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Reference model: C = A * B, kept to 16 bits as the far end returns it
    task automatic model_words(input int n);
        int s;
        words.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += int'(ma[i * n + k]) * int'(mb[k * n + j]);
                words.push_back(16'(s));
            end
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; size = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        @(negedge clk);
        rx_done = 1'b1;
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_frame(input int n);
        exp_tx.push_back(8'(n));
        for (int i = 0; i < n * n; i++) exp_tx.push_back(ma[i]);
        for (int i = 0; i < n * n; i++) exp_tx.push_back(mb[i]);
    endtask

    task automatic send_frame(input int n, input bit pulse_rx);
        int t;
        push_frame(n);
        do_start(n);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wr(1'b1, n * n - 1, ~mb[n * n - 1]);
        if (pulse_rx) rx_pulse(8'hAA);
        t = 0;
        while ((exp_tx.size() != 0 || tx_busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            checks++;
            errors++;
            $display("FAIL tx_frame_timeout: got %0d bytes left, expected 0", exp_tx.size());
        end
        repeat (TX_GAP + 10) @(negedge clk);
    endtask

    task automatic readback(input int addr, input logic [15:0] exp);
        @(negedge clk);
        res_rd_addr = AW'(addr);
        @(negedge clk);
        chk($sformatf("result[%0d]", addr), {16'd0, res_rd_data}, {16'd0, exp});
    endtask

    task automatic recv_check(input int n);
        int d0, t;
        d0 = done_cnt;
        for (int i = 0; i < n * n; i++) begin
            rx_pulse(words[i][15:8]);
            rx_pulse(words[i][7:0]);
        end
        t = 0;
        while (done_cnt == d0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("err_after_done", {31'd0, err}, 32'd0);
        for (int i = 0; i < n * n; i++) readback(i, words[i]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        chk({tag, "_tx_byte"}, {24'd0, tx_byte}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_res_rd_data"}, {16'd0, res_rd_data}, 32'd0);
    endtask

    task automatic bad_size(input int n);
        int s0;
        s0 = tx_seen;
        do_start(n);
        chk("bad_size_err", {31'd0, err}, 32'd1);
        chk("bad_size_code", {30'd0, err_code}, 32'd1);
        chk("bad_size_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        chk("bad_size_no_tx", 32'(tx_seen - s0), 32'd0);
        chk("bad_size_err_held", {31'd0, err}, 32'd1);
        chk("bad_size_busy_late", {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, t, s0;
        rst = 1'b1; start = 1'b0; size = 8'd0; mat_wr_en = 1'b0; mat_wr_sel = 1'b0;
        mat_wr_addr = '0; mat_wr_data = 8'd0; res_rd_addr = '0; rx_byte = 8'd0; rx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // directed N=2 frame from the link description
        for (int i = 0; i < 4; i++) begin
            ma[i] = 8'(i + 1);
            mb[i] = 8'(i + 5);
        end
        load_dut(2);
        words.delete();
        words.push_back(16'd19); words.push_back(16'd22);
        words.push_back(16'd43); words.push_back(16'd50);
        send_frame(2, 1'b0);
        recv_check(2);

        bad_size(1);
        bad_size(11);

        // byte order and hi-byte latch reuse, with an rx edge during transmission
        rand_mats(2);
        load_dut(2);
        words.delete();
        words.push_back(16'hFFFF); words.push_back(16'h1234);
        words.push_back(16'h0001); words.push_back(16'h8000);
        send_frame(2, 1'b1);
        recv_check(2);

        // slow transmitter: busy rises 20 cycles after the request
        busy_delay = 20;
        rand_mats(2);
        load_dut(2);
        model_words(2);
        send_frame(2, 1'b0);
        recv_check(2);
        busy_delay = 0;

        // random jobs, last one at the largest size
        for (int r = 0; r < 4; r++) begin
            n = (r == 3) ? MAX_SIZE : int'($urandom_range(2, MAX_SIZE - 1));
            rand_mats(n);
            load_dut(n);
            model_words(n);
            send_frame(n, r[0]);
            recv_check(n);
        end

        // receive timeout after 5 of 18 result bytes
        rand_mats(3);
        load_dut(3);
        model_words(3);
        send_frame(3, 1'b0);
        s0 = done_cnt;
        rx_pulse(words[0][15:8]); rx_pulse(words[0][7:0]);
        rx_pulse(words[1][15:8]); rx_pulse(words[1][7:0]);
        rx_pulse(words[2][15:8]);
        t = 0;
        while (err !== 1'b1 && t < RX_TIMEOUT + 50) begin
            @(negedge clk);
            t++;
        end
        chk_ge("timeout_delay", t, RX_TIMEOUT - 10);
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_code", {30'd0, err_code}, 32'd2);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_no_done", 32'(done_cnt - s0), 32'd0);
        readback(0, words[0]);
        readback(1, words[1]);

        // reset in the middle of sending A, then a clean frame
        rand_mats(3);
        load_dut(3);
        push_frame(3);
        s0 = tx_count;
        do_start(3);
        t = 0;
        while (!(tx_count >= s0 + 3 && tx_busy === 1'b0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk_ge("rst_mid_progress", tx_count - s0, 3);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        rst = 1'b0;
        exp_tx.delete();
        repeat (5) @(negedge clk);
        rand_mats(3);
        load_dut(3);
        model_words(3);
        send_frame(3, 1'b0);
        recv_check(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
